md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage MIPS pipeline. It owns the HI/LO register pair and accepts multiply, divide, msub and move-to operations issued from the E stage. It models multi-cycle latency with a countdown timer and raises a stall request that freezes the D/E pipeline registers while a D-stage instruction needs HI/LO or the unit. The HI/LO read value feeds the E-stage result path, which then carries it into the M-stage `md` field.

---
 rtl/md_sched.sv | 144 ++++++++++++++
 tb/tb_md_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning the HI/LO pair.
// Multi-cycle latency is modelled by a countdown (cnt != 0 means BUSY).
// Optional feature macro: MD_MSUB_EN enables MSUB/MSUBU (codes 7/8);
// without it those codes decode as NOP and no subtract path exists.
module md_sched #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_out
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } md_op_e;

  // Ops that occupy the unit for a latency period.
  function automatic logic is_compute(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MD_MSUB_EN
      OP_MSUB, OP_MSUBU:                  return 1'b1;
`endif
      default:                            return 1'b0;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        div_ovf;

  // Arithmetic on the latched operands; only consumed at commit.
  always_comb begin
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    // Most-negative / -1 overflows; the architected result is fixed.
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    quo_s   = 32'($signed(a_q) / $signed(b_q));
    rem_s   = 32'($signed(a_q) % $signed(b_q));
    quo_u   = a_q / b_q;
    rem_u   = a_q % b_q;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end
  end

  // Next-state: countdown/commit while busy, issue while idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MD_MSUB_EN
          OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
          OP_DIV: if (b_q != 32'd0) begin
            lo_d = quo_s;
            hi_d = rem_s;
          end
          OP_DIVU: if (b_q != 32'd0) begin
            lo_d = quo_u;
            hi_d = rem_u;
          end
          default: ;
        endcase
      end
    end else if (start) begin
      if (is_compute(md_op)) begin
        a_d   = a;
        b_d   = b;
        op_d  = md_op;
        cnt_d = ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? DIV_CNT : MUL_CNT;
      end else if (md_op == OP_MTHI) begin
        hi_d = a;
      end else if (md_op == OP_MTLO) begin
        lo_d = a;
      end
    end
  end

  // State registers with synchronous reset; reset aborts any in-flight op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
    end
  end

  assign busy   = (cnt_q != '0);
  assign stall  = d_md_use & (busy | (start & is_compute(md_op)));
  assign md_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed testbench for md_sched. Inputs are driven 1ns after the rising
// edge; outputs are sampled within the same cycle, away from the edge.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use, hilo_sel;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] md_out;

  int n_vec = 0;
  int n_err = 0;

  md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .d_md_use(d_md_use), .hilo_sel(hilo_sel),
    .busy(busy), .stall(stall), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hilo_sel = 1'b1; #1;
    check({tag, ".hi"}, md_out, exp_hi);
    hilo_sel = 1'b0; #1;
    check({tag, ".lo"}, md_out, exp_lo);
  endtask

  // Present an op in the current cycle, check stall, then advance one cycle.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic duse, input logic exp_stall);
    start = 1'b1; md_op = op; a = av; b = bv; d_md_use = duse;
    #1;
    check({tag, ".stall_issue"}, {31'd0, stall}, {31'd0, exp_stall});
    step();
    start = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0;
  endtask

  // Check busy/stall over n cycles, then land on the first cycle after.
  task automatic busy_run(input string tag, input int n, input logic exp_busy, input logic exp_stall);
    for (int i = 0; i < n; i++) begin
      check({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
      check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
      step();
    end
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, ".stall_end"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 4'd0; a = '0; b = '0;
    d_md_use = 1'b0; hilo_sel = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst.busy", {31'd0, busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    // MULT -2 * 3 with an md instruction waiting in D.
    issue("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    read_hilo("mult.inflight", 32'd0, 32'd0);
    busy_run("mult", 5, 1'b1, 1'b1);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    d_md_use = 1'b0;

    // MULTU same operands, no D-stage user: stall never asserts.
    issue("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    busy_run("multu", 5, 1'b1, 1'b0);
    read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // DIV -7 / 2.
    issue("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    busy_run("div", 10, 1'b1, 1'b0);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV by zero: full latency, HI/LO unchanged.
    issue("div0", 4'd3, 32'd123, 32'd0, 1'b0, 1'b0);
    busy_run("div0", 10, 1'b1, 1'b0);
    read_hilo("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Signed overflow case.
    issue("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    busy_run("divovf", 10, 1'b1, 1'b0);
    read_hilo("divovf", 32'd0, 32'h8000_0000);

    // Reserved code 9 is a NOP.
    issue("nop9", 4'd9, 32'h1111_1111, 32'd5, 1'b1, 1'b0);
    check("nop9.busy", {31'd0, busy}, 32'd0);
    read_hilo("nop9", 32'd0, 32'h8000_0000);

    // MTHI/MTLO visible the next cycle.
    issue("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    read_hilo("mthi", 32'h1234_5678, 32'h8000_0000);
    issue("mthi0", 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    read_hilo("mthi0", 32'd0, 32'h8000_0000);
    issue("mtlo", 4'd6, 32'd10, 32'd0, 1'b0, 1'b0);
    read_hilo("mtlo", 32'd0, 32'd10);

    // MSUB 3*4 from {0,10}.
`ifdef MD_MSUB_EN
    issue("msub", 4'd7, 32'd3, 32'd4, 1'b1, 1'b1);
    busy_run("msub", 5, 1'b1, 1'b1);
    read_hilo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    d_md_use = 1'b0;
    issue("mtlo2", 4'd6, 32'd10, 32'd0, 1'b0, 1'b0);
    issue("mthi2", 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
`else
    issue("msub", 4'd7, 32'd3, 32'd4, 1'b1, 1'b0);
    busy_run("msub", 5, 1'b0, 1'b0);
    read_hilo("msub", 32'd0, 32'd10);
    d_md_use = 1'b0;
`endif

    // Back-to-back MULTU then DIVU with no idle cycle.
    issue("b2b1", 4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    busy_run("b2b1", 5, 1'b1, 1'b0);
    read_hilo("b2b1", 32'd1, 32'd0);
    issue("b2b2", 4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    busy_run("b2b2", 10, 1'b1, 1'b0);
    read_hilo("b2b2", 32'd2, 32'd14);

    // Reset in cycle 3 of a DIVU aborts it.
    issue("rstdiv", 4'd4, 32'd50, 32'd5, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstdiv.busy", {31'd0, busy}, 32'd0);
    read_hilo("rstdiv", 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("rstdiv.late_busy", {31'd0, busy}, 32'd0);
    read_hilo("rstdiv.late", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
